sram_ctl: RTL and testbench

Parametrised asynchronous-SRAM controller for AS6C1008-class parts (CE1#/CE2/WE#/OE#). It bridges the CPLD's active-low host bus (read_n/write_n/ce_n, address, bidirectional data) onto the SRAM pins. It sequences setup, access and recovery phases with a programmable wait-state count, and reports completion on a ready strobe. It replaces the fixed 7-bit/8-bit, untimed controller used in the lab03 CPLD.

---
 rtl/sram_ctl_if.sv | 24 ++
 rtl/sram_ctl.sv | 163 ++++++++++++++++
 tb/tb_sram_ctl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctl_if.sv
// Host-side control bundle for sram_ctl: chip select, strobes, address,
// and the ready/busy status back to the host.
interface sram_ctl_if #(
    parameter int unsigned ADDR_W = 7
);
    logic              ce_n;
    logic              read_n;
    logic              write_n;
    logic [ADDR_W-1:0] address_bus;
    logic              ready;
    logic              busy;

    // Host side drives the request and watches status
    modport master (
        output ce_n, read_n, write_n, address_bus,
        input  ready, busy
    );

    // Controller side samples the request and reports status
    modport slave (
        input  ce_n, read_n, write_n, address_bus,
        output ready, busy
    );
endinterface

// File: rtl/sram_ctl.sv
// Asynchronous SRAM controller (CE1#/CE2/WE#/OE#) with setup, timed access,
// hold and recovery phases. Optional macro SRAM_CTL_RDBYPASS_EN lets data_bus
// follow mem_data combinationally while OE# is low during a read.
module sram_ctl #(
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned MEM_ADDR_W = 17,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned WAIT_CYC   = 2,
    parameter int unsigned RECOV_CYC  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sram_ctl_if.slave             host,
    inout  wire  [DATA_W-1:0]     data_bus,
    output logic [MEM_ADDR_W-1:0] mem_address,
    inout  wire  [DATA_W-1:0]     mem_data,
    output logic                  ceh_n,
    output logic                  ce2,
    output logic                  we_n,
    output logic                  oe_n
);
    localparam int unsigned CNT_W = 4;

    // Elaboration-time parameter sanity
    if (ADDR_W > MEM_ADDR_W) begin : g_bad_addr_w
        $error("sram_ctl: ADDR_W must not exceed MEM_ADDR_W");
    end
    if (WAIT_CYC < 1 || WAIT_CYC > 15) begin : g_bad_wait
        $error("sram_ctl: WAIT_CYC must be in 1..15");
    end
    if (RECOV_CYC > 3) begin : g_bad_recov
        $error("sram_ctl: RECOV_CYC must be in 0..3");
    end

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD,
        RECOVER,
        WAIT_REL
    } state_t;

    state_t             state;
    logic               op_rd;
    logic               aborted;
    logic               mem_drv;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  wdata;
    logic [DATA_W-1:0]  rdata_q;

    logic               rd_req_c;
    logic               wr_req_c;
    logic               held_c;
    logic               host_drv_c;
    logic [DATA_W-1:0]  host_val_c;

    // Request decode; both strobes low is treated as no request
    assign rd_req_c = !host.ce_n && !host.read_n &&  host.write_n;
    assign wr_req_c = !host.ce_n && !host.write_n && host.read_n;
    // Host still holding the strobe of the latched operation
    assign held_c   = !host.ce_n && (op_rd ? !host.read_n : !host.write_n);

    // Cycle sequencer with registered SRAM strobes and host status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_rd       <= 1'b0;
            aborted     <= 1'b0;
            mem_drv     <= 1'b0;
            cnt         <= '0;
            wdata       <= '0;
            rdata_q     <= '0;
            mem_address <= '0;
            ceh_n       <= 1'b1;
            ce2         <= 1'b0;
            we_n        <= 1'b1;
            oe_n        <= 1'b1;
            host.ready  <= 1'b0;
            host.busy   <= 1'b0;
        end else begin
            host.ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (rd_req_c || wr_req_c) begin
                        state       <= SETUP;
                        mem_address <= MEM_ADDR_W'(host.address_bus);
                        op_rd       <= rd_req_c;
                        wdata       <= data_bus;
                        mem_drv     <= wr_req_c;
                        aborted     <= 1'b0;
                        ceh_n       <= 1'b0;
                        ce2         <= 1'b1;
                        host.busy   <= 1'b1;
                    end
                end
                SETUP: begin
                    state <= ACCESS;
                    cnt   <= CNT_W'(WAIT_CYC - 1);
                    if (op_rd) oe_n <= 1'b0;
                    else       we_n <= 1'b0;
                    if (!held_c) aborted <= 1'b1;
                end
                ACCESS: begin
                    if (!held_c) aborted <= 1'b1;
                    if (cnt == '0) begin
                        state      <= HOLD;
                        oe_n       <= 1'b1;
                        we_n       <= 1'b1;
                        host.ready <= held_c && !aborted;
                        if (op_rd) rdata_q <= mem_data;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    ceh_n   <= 1'b1;
                    ce2     <= 1'b0;
                    mem_drv <= 1'b0;
                    if (RECOV_CYC > 0) begin
                        state <= RECOVER;
                        cnt   <= CNT_W'(RECOV_CYC - 1);
                    end else begin
                        state     <= WAIT_REL;
                        host.busy <= 1'b0;
                    end
                end
                RECOVER: begin
                    if (cnt == '0) begin
                        state     <= WAIT_REL;
                        host.busy <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WAIT_REL: begin
                    if (!held_c) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Host data drive: registered read data once the access has completed
    always_comb begin
        host_drv_c = 1'b0;
        host_val_c = rdata_q;
        if (op_rd && !host.ce_n && !host.read_n &&
            (state == HOLD || state == RECOVER || state == WAIT_REL)) begin
            host_drv_c = 1'b1;
        end
`ifdef SRAM_CTL_RDBYPASS_EN
        else if (op_rd && !oe_n) begin
            host_drv_c = 1'b1;
            host_val_c = mem_data;
        end
`endif
    end

    assign data_bus = host_drv_c ? host_val_c : 'z;
    assign mem_data = mem_drv    ? wdata      : 'z;

endmodule

// File: tb/tb_sram_ctl.sv
// Self-checking bench for sram_ctl with a behavioural SRAM model and a
// scoreboard of expected completions.
module tb_sram_ctl;
    localparam int unsigned ADDR_W     = 7;
    localparam int unsigned MEM_ADDR_W = 17;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned WAIT_CYC   = 2;
    localparam int unsigned RECOV_CYC  = 1;

    typedef struct packed {
        logic                  is_rd;
        logic [MEM_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    wire  [DATA_W-1:0]     data_bus;
    wire  [DATA_W-1:0]     mem_data;
    logic [MEM_ADDR_W-1:0] mem_address;
    logic                  ceh_n, ce2, we_n, oe_n;

    sram_ctl_if #(.ADDR_W(ADDR_W)) bus ();

    sram_ctl #(
        .ADDR_W(ADDR_W), .MEM_ADDR_W(MEM_ADDR_W), .DATA_W(DATA_W),
        .WAIT_CYC(WAIT_CYC), .RECOV_CYC(RECOV_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .host(bus),
        .data_bus(data_bus), .mem_address(mem_address), .mem_data(mem_data),
        .ceh_n(ceh_n), .ce2(ce2), .we_n(we_n), .oe_n(oe_n)
    );

    always #5 clk = ~clk;

    // Host-side data driver (write data or a Hi-Z probe pattern)
    logic              hdrv_en;
    logic [DATA_W-1:0] hdrv_val;
    assign data_bus = hdrv_en ? hdrv_val : 'z;

    // SRAM model: 128 locations, reads combinational on OE#, writes sampled while WE# low
    logic [DATA_W-1:0] mem [128];
    logic              mprobe;
    logic              mdrv_en;
    logic [DATA_W-1:0] mdrv_val;
    always_comb begin
        mdrv_en  = 1'b0;
        mdrv_val = 8'hC3;
        if (!ceh_n && ce2 && !oe_n && we_n) begin
            mdrv_en  = 1'b1;
            mdrv_val = mem[mem_address[6:0]];
        end else if (mprobe) begin
            mdrv_en = 1'b1;
        end
    end
    assign mem_data = mdrv_en ? mdrv_val : 'z;

    always @(posedge clk) begin
        if (!we_n && !ceh_n && ce2) mem[mem_address[6:0]] <= mem_data;
    end

    int   n_chk = 0;
    int   n_bad = 0;
    exp_t sb[$];
    int   ready_cnt = 0;
    int   oe_falls  = 0;
    int   we_low    = 0;
    logic prev_oe   = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to the next falling edge and run the cycle monitor / scoreboard
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (!we_n) we_low++;
        if (!oe_n && prev_oe) oe_falls++;
        prev_oe = oe_n;
        if (!we_n || !oe_n) check("strobe_excl", 32'(!we_n && !oe_n), 32'd0);
        if (rst_n && bus.ready) begin
            ready_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_ready", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_addr", 32'(mem_address), 32'(e.addr));
                if (e.is_rd) check("sb_rd_data", 32'(data_bus), 32'(e.data));
                else         check("sb_wr_mem", 32'(mem[e.addr[6:0]]), 32'(e.data));
            end
        end
    endtask

    task automatic probe_host(input string tag);
        hdrv_val = 8'h3C;
        hdrv_en  = 1'b1;
        #1;
        check(tag, 32'(data_bus), 32'h3C);
        hdrv_en  = 1'b0;
    endtask

    task automatic probe_mem(input string tag);
        mprobe = 1'b1;
        #1;
        check(tag, 32'(mem_data), 32'hC3);
        mprobe = 1'b0;
    endtask

    task automatic start(input logic is_rd, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] data, input logic push);
        exp_t e;
        bus.address_bus = addr;
        bus.ce_n        = 1'b0;
        bus.read_n      = !is_rd;
        bus.write_n     = is_rd;
        hdrv_val        = data;
        hdrv_en         = !is_rd;
        if (push) begin
            e.is_rd = is_rd;
            e.addr  = MEM_ADDR_W'(addr);
            e.data  = data;
            sb.push_back(e);
        end
    endtask

    task automatic release_bus();
        bus.ce_n    = 1'b1;
        bus.read_n  = 1'b1;
        bus.write_n = 1'b1;
        hdrv_en     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ready_k;
        int base_r, base_o, base_w;
        logic [31:0] exp_bit;

        rst_n = 1'b0;
        hdrv_en = 1'b0; hdrv_val = '0; mprobe = 1'b0;
        bus.address_bus = '0;
        release_bus();
        for (int i = 0; i < 128; i++) mem[i] = '0;

        // 1: reset state
        repeat (3) tick();
        check("rst_ceh_n", 32'(ceh_n), 32'd1);
        check("rst_ce2",   32'(ce2),   32'd0);
        check("rst_we_n",  32'(we_n),  32'd1);
        check("rst_oe_n",  32'(oe_n),  32'd1);
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_busy",  32'(bus.busy),  32'd0);
        check("rst_maddr", 32'(mem_address), 32'd0);
        probe_host("rst_data_bus_z");
        probe_mem("rst_mem_data_z");
        rst_n = 1'b1;
        tick(); tick();

        // 2: write 0xA5 to 0x15
        start(1'b0, 7'h15, 8'hA5, 1'b1);
        base_w = we_low; ready_k = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_bit = (k >= 2 && k <= 1 + int'(WAIT_CYC)) ? 32'd0 : 32'd1;
            check($sformatf("wr_we_n_k%0d", k), 32'(we_n), exp_bit);
            exp_bit = (k <= 2 + int'(WAIT_CYC)) ? 32'd0 : 32'd1;
            check($sformatf("wr_ceh_n_k%0d", k), 32'(ceh_n), exp_bit);
            exp_bit = (k <= 2 + int'(WAIT_CYC) + int'(RECOV_CYC)) ? 32'd1 : 32'd0;
            check($sformatf("wr_busy_k%0d", k), 32'(bus.busy), exp_bit);
            if (k <= 2 + int'(WAIT_CYC)) begin
                check($sformatf("wr_mem_data_k%0d", k), 32'(mem_data), 32'hA5);
                check($sformatf("wr_maddr_k%0d", k), 32'(mem_address), 32'h00015);
            end
            if (bus.ready) ready_k = k;
            if (k == 5) probe_mem("wr_recover_mem_z");
        end
        check("wr_we_cycles", 32'(we_low - base_w), 32'(WAIT_CYC));
        check("wr_ready_cycle", 32'(ready_k), 32'(2 + WAIT_CYC));
        release_bus();
        tick();
        probe_mem("wr_idle_mem_z");

        // 3: read back 0x15
        start(1'b1, 7'h15, 8'hA5, 1'b1);
        ready_k = 0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp_bit = (k >= 2 && k <= 1 + int'(WAIT_CYC)) ? 32'd0 : 32'd1;
            check($sformatf("rd_oe_n_k%0d", k), 32'(oe_n), exp_bit);
            if (k >= 2 + int'(WAIT_CYC))
                check($sformatf("rd_data_k%0d", k), 32'(data_bus), 32'hA5);
            if (k == 1) probe_host("rd_setup_data_z");
            if (bus.ready) ready_k = k;
        end
        check("rd_ready_cycle", 32'(ready_k), 32'(2 + WAIT_CYC));
        release_bus();
        probe_host("rd_release_data_z");
        tick();

        // 4: both strobes low is not a request
        base_w = we_low; base_o = oe_falls;
        bus.address_bus = 7'h15; bus.ce_n = 1'b0; bus.read_n = 1'b0; bus.write_n = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("both_busy_k%0d", k), 32'(bus.busy), 32'd0);
            check($sformatf("both_ceh_n_k%0d", k), 32'(ceh_n), 32'd1);
        end
        check("both_we_cycles", 32'(we_low - base_w), 32'd0);
        check("both_oe_falls", 32'(oe_falls - base_o), 32'd0);
        probe_host("both_data_z");
        probe_mem("both_mem_z");
        release_bus();
        tick();

        // 5: held read strobe runs exactly one cycle; re-strobe starts another
        start(1'b0, 7'h2A, 8'h5C, 1'b1);
        repeat (6) tick();
        release_bus();
        tick();
        base_r = ready_cnt; base_o = oe_falls;
        start(1'b1, 7'h2A, 8'h5C, 1'b1);
        repeat (20) tick();
        check("held_ready_cnt", 32'(ready_cnt - base_r), 32'd1);
        check("held_oe_falls", 32'(oe_falls - base_o), 32'd1);
        release_bus();
        tick(); tick();
        start(1'b1, 7'h2A, 8'h5C, 1'b1);
        repeat (8) tick();
        check("restrobe_ready_cnt", 32'(ready_cnt - base_r), 32'd2);
        check("restrobe_oe_falls", 32'(oe_falls - base_o), 32'd2);
        release_bus();
        tick();

        // Host abort: cycle still completes its WE# pulse but no ready
        base_r = ready_cnt; base_w = we_low;
        start(1'b0, 7'h33, 8'h77, 1'b0);
        tick();
        release_bus();
        repeat (8) tick();
        check("abort_ready_cnt", 32'(ready_cnt - base_r), 32'd0);
        check("abort_we_cycles", 32'(we_low - base_w), 32'(WAIT_CYC));
        check("abort_busy_end", 32'(bus.busy), 32'd0);

        // 6: asynchronous reset during write access
        base_r = ready_cnt;
        start(1'b0, 7'h10, 8'h99, 1'b0);
        tick(); tick();
        check("mid_we_n_pre", 32'(we_n), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_we_n",  32'(we_n),  32'd1);
        check("mid_ceh_n", 32'(ceh_n), 32'd1);
        check("mid_ce2",   32'(ce2),   32'd0);
        check("mid_busy",  32'(bus.busy), 32'd0);
        release_bus();
        probe_mem("mid_mem_z");
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        check("post_rst_busy", 32'(bus.busy), 32'd0);
        check("post_rst_ceh_n", 32'(ceh_n), 32'd1);
        check("post_rst_ready_cnt", 32'(ready_cnt - base_r), 32'd0);
        probe_host("post_rst_data_z");

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
